// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer
// Packs IN_WIDTH-bit beats into OUT_WIDTH-bit words for the write side of an
// async FIFO. Beats fill lanes LSB-first. A word closes on the last lane, on
// in_last, or on flush. A closed word sits in a holding register until the
// FIFO has room. Holding can be refilled on the same edge it drains, so
// back-to-back words write once per cycle.
//
// Build option: define FIFO_WR_PACKER_KEEP_EN to append a per-lane keep mask
// above the packed data on wr_data (bit i set when lane i carries a beat).
module fifo_wr_packer #(
    parameter int IN_WIDTH   = 8,
    parameter int PACK_RATIO = 4,
    localparam int OUT_WIDTH = IN_WIDTH * PACK_RATIO
) (
    input  logic                  wr_clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic                  fifo_full,
    output logic                  wr_en,
`ifdef FIFO_WR_PACKER_KEEP_EN
    output logic [OUT_WIDTH+PACK_RATIO-1:0] wr_data,
`else
    output logic [OUT_WIDTH-1:0]  wr_data,
`endif
    output logic [15:0]           words_written
);

    localparam int LANE_W = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;

    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [OUT_WIDTH-1:0] asm_q, asm_d;
    logic [OUT_WIDTH-1:0] hold_q, hold_d;
    logic                 pending_q, pending_d;
    logic [15:0]          cnt_q, cnt_d;

    logic                 accept;
    logic                 last_lane;
    logic                 close;
    logic [OUT_WIDTH-1:0] merged;

`ifdef FIFO_WR_PACKER_KEEP_EN
    logic [PACK_RATIO-1:0] asm_keep_q, asm_keep_d;
    logic [PACK_RATIO-1:0] hold_keep_q, hold_keep_d;
    logic [PACK_RATIO-1:0] merged_keep;
`endif

    // Handshake and close decision. A flush with nothing in the assembly
    // register, or while stalled, is simply dropped.
    always_comb begin
        in_ready  = !pending_q || !fifo_full;
        wr_en     = pending_q && !fifo_full;
        accept    = in_valid && in_ready;
        last_lane = (lane_q == LANE_W'(PACK_RATIO - 1));
        if (accept) begin
            close = last_lane || in_last || flush;
        end else begin
            close = flush && in_ready && (lane_q != '0);
        end
    end

    // Assembly word including the beat accepted this cycle (if any).
    always_comb begin
        merged = asm_q;
        for (int i = 0; i < PACK_RATIO; i++) begin
            if (accept && (lane_q == LANE_W'(i))) begin
                merged[i*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
    end

`ifdef FIFO_WR_PACKER_KEEP_EN
    // Keep mask tracks which lanes of the assembly word hold beats.
    always_comb begin
        merged_keep = asm_keep_q;
        for (int i = 0; i < PACK_RATIO; i++) begin
            if (accept && (lane_q == LANE_W'(i))) begin
                merged_keep[i] = 1'b1;
            end
        end
        asm_keep_d  = asm_keep_q;
        hold_keep_d = hold_keep_q;
        if (close) begin
            asm_keep_d  = '0;
            hold_keep_d = merged_keep;
        end else if (accept) begin
            asm_keep_d  = merged_keep;
        end
    end
`endif

    // Next-state for lane counter, assembly, holding register and counter.
    // Clearing the assembly register on close keeps unfilled lanes at zero.
    always_comb begin
        lane_d    = lane_q;
        asm_d     = asm_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        if (close) begin
            lane_d    = '0;
            asm_d     = '0;
            hold_d    = merged;
            pending_d = 1'b1;
        end else begin
            if (accept) begin
                lane_d = lane_q + LANE_W'(1);
                asm_d  = merged;
            end
            if (wr_en) begin
                pending_d = 1'b0;
            end
        end
        if (wr_en) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State registers.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q    <= '0;
            asm_q     <= '0;
            hold_q    <= '0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            lane_q    <= lane_d;
            asm_q     <= asm_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef FIFO_WR_PACKER_KEEP_EN
    // Keep-mask registers.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_keep_q  <= '0;
            hold_keep_q <= '0;
        end else begin
            asm_keep_q  <= asm_keep_d;
            hold_keep_q <= hold_keep_d;
        end
    end

    assign wr_data = {hold_keep_q, hold_q};
`else
    assign wr_data = hold_q;
`endif

    assign words_written = cnt_q;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Scoreboard bench for fifo_wr_packer (IN_WIDTH=8, PACK_RATIO=4).
// Driver applies inputs at the falling edge and runs a beat-list model; closed
// words go into exp_q. The monitor pops exp_q whenever the DUT writes.
module tb_fifo_wr_packer;

    localparam int IW = 8;
    localparam int PR = 4;
    localparam int OW = IW * PR;
`ifdef FIFO_WR_PACKER_KEEP_EN
    localparam int WW = OW + PR;
`else
    localparam int WW = OW;
`endif

    logic          wr_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          flush = 1'b0;
    logic          fifo_full = 1'b0;
    logic          wr_en;
    logic [WW-1:0] wr_data;
    logic [15:0]   words_written;

    int tests = 0;
    int fails = 0;

    logic [IW-1:0] m_beats[$];
    logic [WW-1:0] exp_q[$];
    bit            m_pend = 1'b0;
    int            m_cnt = 0;

    fifo_wr_packer #(.IN_WIDTH(IW), .PACK_RATIO(PR)) dut (
        .wr_clk        (wr_clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .flush         (flush),
        .fifo_full     (fifo_full),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .words_written (words_written)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] build_word();
        logic [WW-1:0] w;
        w = '0;
        foreach (m_beats[i]) begin
            w[i*IW +: IW] = m_beats[i];
`ifdef FIFO_WR_PACKER_KEEP_EN
            w[OW + i] = 1'b1;
`endif
        end
        return w;
    endfunction

    // One cycle: apply inputs, check handshake outputs, advance the model.
    task automatic drive(input logic v, input logic [IW-1:0] d, input logic l,
                         input logic f, input logic ff);
        bit exp_ready, acc, wr, cl;
        @(negedge wr_clk);
        in_valid = v; in_data = d; in_last = l; flush = f; fifo_full = ff;
        #1;
        exp_ready = !m_pend || !ff;
        acc       = v && exp_ready;
        wr        = m_pend && !ff;
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("wr_en", 64'(wr_en), 64'(wr));
        chk("words_written", 64'(words_written), 64'(m_cnt[15:0]));
        if (m_pend && exp_q.size() > 0) chk("held_word", 64'(wr_data), 64'(exp_q[0]));
        if (wr) m_cnt++;
        cl = 1'b0;
        if (acc) begin
            m_beats.push_back(d);
            if (m_beats.size() == PR || l || f) cl = 1'b1;
        end else if (f && exp_ready && m_beats.size() != 0) begin
            cl = 1'b1;
        end
        if (cl) begin
            exp_q.push_back(build_word());
            m_beats.delete();
            m_pend = 1'b1;
        end else if (wr) begin
            m_pend = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; in_last = 1'b0; fifo_full = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_words", 64'(words_written), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        m_beats.delete(); exp_q.delete(); m_pend = 1'b0; m_cnt = 0;
        @(negedge wr_clk);
        rst_n = 1'b1;
    endtask

    // Monitor: each DUT write must match the oldest expected word.
    initial begin
        forever begin
            @(negedge wr_clk);
            #2;
            if (rst_n && wr_en) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: got 0x%0h expected none", wr_data);
                end else begin
                    chk("sb_wr_data", 64'(wr_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        do_reset();

        // Full word, one write the cycle after the fourth beat.
        drive(1, 8'h11, 0, 0, 0); drive(1, 8'h22, 0, 0, 0);
        drive(1, 8'h33, 0, 0, 0); drive(1, 8'h44, 0, 0, 0);
        drive(0, 8'h00, 0, 0, 0);
        chk("full_word_wr_en", 64'(wr_en), 64'd1);
        chk("full_word_data", 64'(wr_data[OW-1:0]), 64'h44332211);
        idle(1);
        chk("full_word_count", 64'(words_written), 64'd1);
        chk("full_word_single", 64'(wr_en), 64'd0);

        // Short word closed by in_last; next beat restarts in lane 0.
        drive(1, 8'hA1, 0, 0, 0); drive(1, 8'hA2, 1, 0, 0);
        drive(1, 8'hB1, 0, 0, 0);
        chk("last_word_data", 64'(wr_data[OW-1:0]), 64'h0000A2A1);
        drive(1, 8'hB2, 0, 0, 0); drive(1, 8'hB3, 0, 0, 0); drive(1, 8'hB4, 0, 0, 0);
        idle(1);
        chk("lane0_restart", 64'(wr_data[OW-1:0]), 64'hB4B3B2B1);
        idle(1);

        // Stall on fifo_full for 5 cycles, then exactly one write.
        drive(1, 8'hC1, 0, 0, 0); drive(1, 8'hC2, 0, 0, 0);
        drive(1, 8'hC3, 0, 0, 0); drive(1, 8'hC4, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, 8'hEE, 0, 1, 1);
        chk("stall_data", 64'(wr_data[OW-1:0]), 64'hC4C3C2C1);
        idle(2);

        // Flush of a one-beat partial word; flush at lane 0 does nothing.
        drive(1, 8'h55, 0, 0, 0);
        drive(0, 8'h00, 0, 1, 0);
        drive(0, 8'h00, 0, 1, 0);
        chk("flush_data", 64'(wr_data[OW-1:0]), 64'h00000055);
        idle(3);

        // Flush together with an accepted beat closes including that beat.
        drive(1, 8'h61, 0, 0, 0); drive(1, 8'h62, 0, 1, 0);
        idle(2);

        // Reset mid-word discards it.
        drive(1, 8'h71, 0, 0, 0); drive(1, 8'h72, 0, 0, 0); drive(1, 8'h73, 0, 0, 0);
        do_reset();
        drive(1, 8'h01, 0, 0, 0); drive(1, 8'h02, 0, 0, 0);
        drive(1, 8'h03, 0, 0, 0); drive(1, 8'h04, 0, 0, 0);
        idle(1);
        chk("post_reset_word", 64'(wr_data[OW-1:0]), 64'h04030201);
        idle(1);
        chk("post_reset_count", 64'(words_written), 64'd1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0, IW'($urandom), ($urandom % 6) == 0,
                  ($urandom % 8) == 0, ($urandom % 4) == 0);
        end
        idle(4);
        chk("random_drained", 64'(exp_q.size()), 64'd0);

        // Counter wrap: 65535 single-beat words, then one more.
        do_reset();
        for (int i = 0; i < 65535; i++) drive(1, IW'($urandom), 1, 0, 0);
        idle(2);
        chk("count_ffff", 64'(words_written), 64'hFFFF);
        drive(1, 8'h99, 1, 0, 0);
        idle(2);
        chk("count_wrap", 64'(words_written), 64'h0000);
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
